// File: rtl/calcn_core.sv
// calcn_core: NUM_PORTS tagged two-operand requesters sharing one ALU through per-port FIFOs and a round-robin arbiter.
module calcn_core #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        c_clk,
  input  logic                        reset,
  input  logic [NUM_PORTS*4-1:0]      req_cmd_in,
  input  logic [NUM_PORTS*DATA_W-1:0] req_data_in,
  input  logic [NUM_PORTS*TAG_W-1:0]  req_tag_in,
  output logic [NUM_PORTS-1:0]        req_ready,
  output logic [NUM_PORTS*2-1:0]      out_resp,
  output logic [NUM_PORTS*DATA_W-1:0] out_data,
  output logic [NUM_PORTS*TAG_W-1:0]  out_tag
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  localparam int SW = $clog2(DATA_W);
  localparam int HW = 4 + TAG_W + DATA_W;
  localparam int EW = HW + DATA_W;

  logic [NUM_PORTS-1:0]        pend_q, pend_d;
  logic [HW-1:0]               hold_q [NUM_PORTS];
  logic [HW-1:0]               hold_d [NUM_PORTS];
  logic [EW-1:0]               mem_q [NUM_PORTS][FIFO_DEPTH];
  logic [EW-1:0]               mem_d [NUM_PORTS][FIFO_DEPTH];
  logic [AW-1:0]               wp_q [NUM_PORTS];
  logic [AW-1:0]               wp_d [NUM_PORTS];
  logic [AW-1:0]               rp_q [NUM_PORTS];
  logic [AW-1:0]               rp_d [NUM_PORTS];
  logic [CW-1:0]               cnt_q [NUM_PORTS];
  logic [CW-1:0]               cnt_d [NUM_PORTS];
  logic [PW-1:0]               rr_q, rr_d, gnt, idx;
  logic                        gnt_v;
  logic [EW-1:0]               head;
  logic [3:0]                  cmd;
  logic [DATA_W-1:0]           op_a, op_b, res;
  logic [DATA_W:0]             sum;
  logic [1:0]                  resp;
  logic [NUM_PORTS*2-1:0]      resp_q, resp_d;
  logic [NUM_PORTS*DATA_W-1:0] data_q, data_d;
  logic [NUM_PORTS*TAG_W-1:0]  tag_q, tag_d;

  assign out_resp = resp_q;
  assign out_data = data_q;
  assign out_tag  = tag_q;

  // A pending operand capture reserves its slot, so an accepted request can always be written.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++)
      req_ready[p] = (cnt_q[p] + CW'(pend_q[p])) < CW'(FIFO_DEPTH);
  end

  always_comb begin
    gnt_v = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = PW'((int'(rr_q) + i) % NUM_PORTS);
      if (!gnt_v && cnt_q[idx] != '0) begin
        gnt_v = 1'b1;
        gnt   = idx;
      end
    end
    head = mem_q[gnt][rp_q[gnt]];
    cmd  = head[EW-1 -: 4];
    op_a = head[DATA_W +: DATA_W];
    op_b = head[0 +: DATA_W];
    sum  = {1'b0, op_a} + {1'b0, op_b};
    res  = cmd == 4'd1 ? (sum[DATA_W] ? '0 : sum[DATA_W-1:0]) :
           cmd == 4'd2 ? (op_b > op_a ? '0 : op_a - op_b) :
           cmd == 4'd5 ? op_a << op_b[SW-1:0] :
           cmd == 4'd6 ? op_a >> op_b[SW-1:0] : '0;
    resp = ((cmd == 4'd1 && !sum[DATA_W]) || (cmd == 4'd2 && op_b <= op_a) ||
            cmd == 4'd5 || cmd == 4'd6) ? 2'd1 : 2'd2;
    rr_d = !gnt_v ? rr_q : (int'(gnt) == NUM_PORTS - 1) ? '0 : gnt + PW'(1);
  end

  always_comb begin
    pend_d = pend_q;
    hold_d = hold_q;
    mem_d  = mem_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    cnt_d  = cnt_q;
    resp_d = '0;
    data_d = '0;
    tag_d  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (pend_q[p]) begin
        mem_d[p][wp_q[p]] = {hold_q[p], req_data_in[p*DATA_W +: DATA_W]};
        wp_d[p]           = wp_q[p] + AW'(1);
        pend_d[p]         = 1'b0;
      end else if (req_cmd_in[p*4 +: 4] != 4'd0 && req_ready[p]) begin
        pend_d[p] = 1'b1;
        hold_d[p] = {req_cmd_in[p*4 +: 4], req_tag_in[p*TAG_W +: TAG_W], req_data_in[p*DATA_W +: DATA_W]};
      end
      if (gnt_v && gnt == PW'(p)) begin
        rp_d[p]                   = rp_q[p] + AW'(1);
        resp_d[p*2 +: 2]          = resp;
        data_d[p*DATA_W +: DATA_W] = res;
        tag_d[p*TAG_W +: TAG_W]    = head[2*DATA_W +: TAG_W];
      end
      cnt_d[p] = cnt_q[p] + CW'(pend_q[p]) - CW'(gnt_v && gnt == PW'(p));
    end
  end

  always_ff @(posedge c_clk) begin
    mem_q  <= mem_d;
    hold_q <= hold_d;
    if (reset) begin
      pend_q <= '0;
      wp_q   <= '{default: '0};
      rp_q   <= '{default: '0};
      cnt_q  <= '{default: '0};
      rr_q   <= '0;
      resp_q <= '0;
      data_q <= '0;
      tag_q  <= '0;
    end else begin
      pend_q <= pend_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      rr_q   <= rr_d;
      resp_q <= resp_d;
      data_q <= data_d;
      tag_q  <= tag_d;
    end
  end
endmodule
